// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - default widths, NOP control word and control field layout for pipe_stage
package pipe_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int CTRL_W_DEF = 24;
    localparam logic [CTRL_W_DEF-1:0] NOP_CTRL_DEF = '0;

    // Control word layout, LSB first; bits above WREG are spare.
    localparam int ALUOP_OFS   = 0;
    localparam int ALUOP_W     = 4;
    localparam int ALU1SEL_OFS = 4;
    localparam int ALU1SEL_W   = 2;
    localparam int ALU2SEL_OFS = 6;
    localparam int ALU2SEL_W   = 2;
    localparam int MEMWE_OFS   = 8;
    localparam int MEMRE_OFS   = 9;
    localparam int REGWE_OFS   = 10;
    localparam int REGWSEL_OFS = 11;
    localparam int REGWSEL_W   = 2;
    localparam int HALT_OFS    = 13;
    localparam int WREG_OFS    = 14;
    localparam int WREG_W      = 4;

    typedef struct packed {
        logic [WREG_W-1:0]    wreg;
        logic                 halt;
        logic [REGWSEL_W-1:0] regwsel;
        logic                 regwe;
        logic                 memre;
        logic                 memwe;
        logic [ALU2SEL_W-1:0] alu2sel;
        logic [ALU1SEL_W-1:0] alu1sel;
        logic [ALUOP_W-1:0]   aluop;
    } ctrl_fields_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - one {ctrl,data} pipeline entry with its valid bit
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int                 DATA_W   = DATA_W_DEF,
    parameter int                 CTRL_W   = CTRL_W_DEF,
    parameter logic [CTRL_W-1:0]  NOP_CTRL = CTRL_W'(NOP_CTRL_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic              wr_valid_i,
    input  logic [CTRL_W-1:0] wr_ctrl_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;

    // Invalidating writes park ctrl at NOP but leave the data payload alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= NOP_CTRL;
            data_q  <= '0;
        end else if (wr_en_i) begin
            valid_q <= wr_valid_i;
            if (wr_valid_i) begin
                ctrl_q <= wr_ctrl_i;
                data_q <= wr_data_i;
            end else begin
                ctrl_q <= NOP_CTRL;
            end
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - pipeline stage register with handshake, stall and flush; PIPE_STAGE_SKID_EN adds a 2-entry skid
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int                 DATA_W   = DATA_W_DEF,
    parameter int                 CTRL_W   = CTRL_W_DEF,
    parameter logic [CTRL_W-1:0]  NOP_CTRL = CTRL_W'(NOP_CTRL_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              stall,
    input  logic              flush,
    output logic [1:0]        occupancy
);

    logic              accept;
    logic              deliver;
    logic [1:0]        occ_q;
    logic [1:0]        occ_d;
    logic              m_valid;
    logic [CTRL_W-1:0] m_ctrl;
    logic [DATA_W-1:0] m_data;
    logic              m_wr_en;
    logic              m_wr_valid;
    logic [CTRL_W-1:0] m_wr_ctrl;
    logic [DATA_W-1:0] m_wr_data;

    assign out_valid = m_valid & ~stall;
    assign out_ctrl  = out_valid ? m_ctrl : NOP_CTRL;
    assign out_data  = m_data;
    assign deliver   = out_valid & out_ready;
    assign accept    = in_valid & in_ready;
    assign occupancy = occ_q;

    pipe_skid_buf #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .NOP_CTRL(NOP_CTRL)) u_main (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (m_wr_en),
        .wr_valid_i (m_wr_valid),
        .wr_ctrl_i  (m_wr_ctrl),
        .wr_data_i  (m_wr_data),
        .valid_o    (m_valid),
        .ctrl_o     (m_ctrl),
        .data_o     (m_data)
    );

`ifdef PIPE_STAGE_SKID_EN
    logic              ready_q;
    logic              s_valid;
    logic [CTRL_W-1:0] s_ctrl;
    logic [DATA_W-1:0] s_data;
    logic              s_wr_en;
    logic              s_wr_valid;

    // Registered room indicator keeps out_ready out of the in_ready path.
    assign in_ready = ready_q & ~stall & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q <= 1'b1;
        end else begin
            ready_q <= (occ_d < 2'd2);
        end
    end

    always_comb begin
        m_wr_en    = 1'b0;
        m_wr_valid = 1'b0;
        m_wr_ctrl  = in_ctrl;
        m_wr_data  = in_data;
        s_wr_en    = 1'b0;
        s_wr_valid = 1'b0;
        if (flush) begin
            m_wr_en = 1'b1;
            s_wr_en = 1'b1;
        end else if (deliver) begin
            m_wr_en = 1'b1;
            if (s_valid) begin
                m_wr_valid = 1'b1;
                m_wr_ctrl  = s_ctrl;
                m_wr_data  = s_data;
                s_wr_en    = 1'b1;
                s_wr_valid = accept;
            end else begin
                m_wr_valid = accept;
            end
        end else if (accept) begin
            if (m_valid) begin
                s_wr_en    = 1'b1;
                s_wr_valid = 1'b1;
            end else begin
                m_wr_en    = 1'b1;
                m_wr_valid = 1'b1;
            end
        end
    end

    pipe_skid_buf #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .NOP_CTRL(NOP_CTRL)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (s_wr_en),
        .wr_valid_i (s_wr_valid),
        .wr_ctrl_i  (in_ctrl),
        .wr_data_i  (in_data),
        .valid_o    (s_valid),
        .ctrl_o     (s_ctrl),
        .data_o     (s_data)
    );
`else
    assign in_ready   = ~stall & ~flush & (~m_valid | out_ready);
    assign m_wr_en    = flush | accept | deliver;
    assign m_wr_valid = ~flush & accept;
    assign m_wr_ctrl  = in_ctrl;
    assign m_wr_data  = in_data;
`endif

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (accept & ~deliver) begin
            occ_d = occ_q + 2'd1;
        end else if (deliver & ~accept) begin
            occ_d = occ_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

endmodule
